// File: rtl/int2fp32_share_arb.sv
// int2fp32_share_arb
//   Shares one integer-to-float32 converter between NUM_REQ requesters.
//   A round-robin arbiter picks one valid requester per cycle; the granted
//   integer is captured (S1), converted combinationally, and registered with
//   the requester index (S2) so the consumer can route the result back.
//   Conversion truncates toward zero; never produces inf, NaN or denormals.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   req_valid  per-requester valid            [NUM_REQ]
//   req_int    requester i integer at bits [32*i+31:32*i]
//   req_ready  per-requester accept (one-hot or zero)
//   res_valid  result valid
//   res_ready  consumer accept
//   res_float  IEEE-754 single result
//   res_id     index of the requester that issued the result
//   busy       either pipeline stage holds valid data
//
// Configuration
//   INT2FP_SIGNED_IN_EN  defined: two's complement inputs, sign carried to
//                        res_float[31]; undefined: unsigned inputs.

module int2fp32_share_arb #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [32*NUM_REQ-1:0]  req_int,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [31:0]            res_float,
    output logic [ID_W-1:0]        res_id,
    output logic                   busy
);

    logic [ID_W-1:0] ptr;

    // S1 capture register
    logic            v1;
    logic [31:0]     s1_mag;
    logic [ID_W-1:0] s1_id;
    logic            s1_sign;

    logic            adv2;
    logic            load1;
    logic            any_grant;
    logic [ID_W-1:0] grant_idx;
    logic [31:0]     sel_int;
    logic [31:0]     sel_mag;
    logic            sel_sign;
    logic [31:0]     conv;

    assign adv2  = v1 && (!res_valid || res_ready);
    assign load1 = !v1 || adv2;
    assign busy  = v1 || res_valid;

    // Grant depends on req_valid and the pointer only.
    always_comb begin
        int unsigned idx;
        any_grant = 1'b0;
        grant_idx = '0;
        sel_int   = '0;
        idx       = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!any_grant && req_valid[idx]) begin
                any_grant = 1'b1;
                grant_idx = ID_W'(idx);
                sel_int   = req_int[32*idx +: 32];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (any_grant && load1 && !rst) req_ready[grant_idx] = 1'b1;
    end

`ifdef INT2FP_SIGNED_IN_EN
    // 0x80000000 negates to itself, which is the correct unsigned magnitude.
    assign sel_sign = sel_int[31];
    assign sel_mag  = sel_int[31] ? (~sel_int + 32'd1) : sel_int;
`else
    assign sel_sign = 1'b0;
    assign sel_mag  = sel_int;
`endif

    // Converter: normalise so the leading one lands in bit 31, then take the
    // 23 bits below it as the truncated mantissa.
    always_comb begin
        logic [4:0]  msb;
        logic [31:0] norm;
        logic [7:0]  expo;
        msb  = '0;
        for (int unsigned b = 0; b < 32; b++) begin
            if (s1_mag[b]) msb = 5'(b);
        end
        norm = s1_mag << (5'd31 - msb);
        expo = {3'b000, msb} + 8'd127;
        if (s1_mag == '0) conv = '0;
        else              conv = {s1_sign, expo, 23'(norm >> 8)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            v1        <= 1'b0;
            s1_mag    <= '0;
            s1_id     <= '0;
            s1_sign   <= 1'b0;
            res_valid <= 1'b0;
            res_float <= '0;
            res_id    <= '0;
        end else begin
            if (adv2) begin
                res_float <= conv;
                res_id    <= s1_id;
                res_valid <= 1'b1;
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end

            if (load1) begin
                v1 <= any_grant;
                if (any_grant) begin
                    s1_mag  <= sel_mag;
                    s1_id   <= grant_idx;
                    s1_sign <= sel_sign;
                    ptr     <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_int2fp32_share_arb.sv
module tb_int2fp32_share_arb;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [127:0] req_int;
    logic [3:0]   req_ready;
    logic         res_valid;
    logic         res_ready;
    logic [31:0]  res_float;
    logic [1:0]   res_id;
    logic         busy;

    int checks = 0;
    int passes = 0;

    int2fp32_share_arb #(.NUM_REQ(4), .ID_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_int   (req_int),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_float (res_float),
        .res_id    (res_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // 1 unit later, well away from the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_int   = '0;
        res_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 4'b1111;
        req_int   = '0;
        res_ready = 1'b1;
        step();
        step();
        #1;
        checks++; if (req_ready !== 4'b0000) $display("FAIL rst_ready got=%b exp=0000", req_ready); else passes++;
        checks++; if (res_valid !== 1'b0) $display("FAIL rst_res_valid got=%b exp=0", res_valid); else passes++;
        checks++; if (res_float !== 32'h0) $display("FAIL rst_res_float got=%h exp=00000000", res_float); else passes++;
        checks++; if (res_id !== 2'd0) $display("FAIL rst_res_id got=%0d exp=0", res_id); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else passes++;
        req_valid = '0;
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [31:0] ins  [2];
        logic [31:0] exps [2];
        ins[0] = 32'd4;   exps[0] = 32'h40800000;
        ins[1] = 32'd546; exps[1] = 32'h44088000;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (i < 2) begin
                req_valid = 4'b0001;
                req_int[31:0] = ins[i];
                #1;
                checks++; if (req_ready !== 4'b0001) $display("FAIL single_ready%0d got=%b exp=0001", i, req_ready); else passes++;
            end else begin
                req_valid = '0;
            end
            step();
            if (i == 0) begin
                checks++; if (res_valid !== 1'b0) $display("FAIL single_early got=%b exp=0", res_valid); else passes++;
            end else if (i < 3) begin
                checks++; if (res_valid !== 1'b1) $display("FAIL single_valid%0d got=%b exp=1", i, res_valid); else passes++;
                checks++; if (res_float !== exps[i-1]) $display("FAIL single_float%0d got=%h exp=%h", i, res_float, exps[i-1]); else passes++;
                checks++; if (res_id !== 2'd0) $display("FAIL single_id%0d got=%0d exp=0", i, res_id); else passes++;
            end else begin
                checks++; if (res_valid !== 1'b0) $display("FAIL single_drain got=%b exp=0", res_valid); else passes++;
            end
        end
    endtask

    task automatic test_edge();
        logic [31:0] ins  [3];
        logic [31:0] exps [3];
        ins[0] = 32'h00000000; exps[0] = 32'h00000000;
        ins[1] = 32'h00000001; exps[1] = 32'h3F800000;
        ins[2] = 32'hFFFFFFFF;
`ifdef INT2FP_SIGNED_IN_EN
        exps[2] = 32'hBF800000;
`else
        exps[2] = 32'h4F7FFFFF;
`endif
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                req_valid = 4'b0001;
                req_int[31:0] = ins[i];
            end else begin
                req_valid = '0;
            end
            step();
            if (i >= 1) begin
                checks++; if (res_valid !== 1'b1) $display("FAIL edge_valid%0d got=%b exp=1", i, res_valid); else passes++;
                checks++; if (res_float !== exps[i-1]) $display("FAIL edge_float%0d got=%h exp=%h", i, res_float, exps[i-1]); else passes++;
            end
        end
        step();
        checks++; if (busy !== 1'b0) $display("FAIL edge_idle_busy got=%b exp=0", busy); else passes++;
    endtask

    task automatic test_round_robin();
        logic [31:0] exps [4];
        exps[0] = 32'h3F800000;
        exps[1] = 32'h40000000;
        exps[2] = 32'h40400000;
        exps[3] = 32'h40800000;
        do_reset();
        req_int   = {32'd4, 32'd3, 32'd2, 32'd1};
        req_valid = 4'b1111;
        for (int k = 0; k < 7; k++) begin
            #1;
            checks++; if (req_ready !== (4'b0001 << (k % 4))) $display("FAIL rr_ready%0d got=%b exp=%b", k, req_ready, 4'b0001 << (k % 4)); else passes++;
            step();
            if (k >= 1) begin
                checks++; if (res_valid !== 1'b1) $display("FAIL rr_valid%0d got=%b exp=1", k, res_valid); else passes++;
                checks++; if (res_id !== 2'((k - 1) % 4)) $display("FAIL rr_id%0d got=%0d exp=%0d", k, res_id, (k - 1) % 4); else passes++;
                checks++; if (res_float !== exps[(k - 1) % 4]) $display("FAIL rr_float%0d got=%h exp=%h", k, res_float, exps[(k - 1) % 4]); else passes++;
            end
        end
        req_valid = '0;
        step();
        step();
    endtask

    task automatic test_backpressure();
        logic [31:0] exps [3];
        exps[0] = 32'h40A00000;
        exps[1] = 32'h40C00000;
        exps[2] = 32'h40E00000;
        do_reset();
        req_int   = {32'd0, 32'd7, 32'd6, 32'd5};
        req_valid = 4'b0111;
        res_ready = 1'b0;
        step();
        step();
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (res_valid !== 1'b1) $display("FAIL bp_valid%0d got=%b exp=1", c, res_valid); else passes++;
            checks++; if (res_float !== exps[0]) $display("FAIL bp_float%0d got=%h exp=%h", c, res_float, exps[0]); else passes++;
            checks++; if (res_id !== 2'd0) $display("FAIL bp_id%0d got=%0d exp=0", c, res_id); else passes++;
            checks++; if (req_ready !== 4'b0000) $display("FAIL bp_ready%0d got=%b exp=0000", c, req_ready); else passes++;
            checks++; if (busy !== 1'b1) $display("FAIL bp_busy%0d got=%b exp=1", c, busy); else passes++;
            step();
        end
        res_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0100) $display("FAIL bp_release_ready got=%b exp=0100", req_ready); else passes++;
        for (int j = 1; j <= 4; j++) begin
            step();
            checks++; if (res_valid !== 1'b1) $display("FAIL bp_stream_valid%0d got=%b exp=1", j, res_valid); else passes++;
            checks++; if (res_id !== 2'(j % 3)) $display("FAIL bp_stream_id%0d got=%0d exp=%0d", j, res_id, j % 3); else passes++;
            checks++; if (res_float !== exps[j % 3]) $display("FAIL bp_stream_float%0d got=%h exp=%h", j, res_float, exps[j % 3]); else passes++;
        end
        req_valid = '0;
        step();
        step();
    endtask

    task automatic test_reset_midop();
        do_reset();
        req_int   = {32'd4, 32'd3, 32'd2, 32'd1};
        req_valid = 4'b1111;
        res_ready = 1'b0;
        step();
        step();
        checks++; if (res_valid !== 1'b1) $display("FAIL mid_full got=%b exp=1", res_valid); else passes++;
        rst = 1'b1;
        step();
        rst       = 1'b0;
        req_valid = '0;
        res_ready = 1'b1;
        #1;
        checks++; if (res_valid !== 1'b0) $display("FAIL mid_res_valid got=%b exp=0", res_valid); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL mid_busy got=%b exp=0", busy); else passes++;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++; if (res_valid !== 1'b0) $display("FAIL mid_stale%0d got=%b exp=0", c, res_valid); else passes++;
        end
        req_valid = 4'b1111;
        #1;
        checks++; if (req_ready !== 4'b0001) $display("FAIL mid_ptr got=%b exp=0001", req_ready); else passes++;
        req_valid = '0;
        step();
        step();
    endtask

`ifdef INT2FP_SIGNED_IN_EN
    task automatic test_signed();
        logic [31:0] ins  [3];
        logic [31:0] exps [3];
        ins[0] = 32'hFFFFFFFF; exps[0] = 32'hBF800000;
        ins[1] = 32'hFFFFFDDE; exps[1] = 32'hC4088000;
        ins[2] = 32'h80000000; exps[2] = 32'hCF000000;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                req_valid = 4'b0001;
                req_int[31:0] = ins[i];
            end else begin
                req_valid = '0;
            end
            step();
            if (i >= 1) begin
                checks++; if (res_float !== exps[i-1]) $display("FAIL signed_float%0d got=%h exp=%h", i, res_float, exps[i-1]); else passes++;
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_edge();
        test_round_robin();
        test_backpressure();
        test_reset_midop();
`ifdef INT2FP_SIGNED_IN_EN
        test_signed();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
